// File: rtl/pc_gen.sv
// pc_gen: fetch-stage program counter for an RV32I core.
// Adds a reset/trap FSM, fetch handshake, stall, prioritised redirects
// (trap, trap-return, branch/jump, RAS pop), misaligned-target trapping
// and a small circular return-address stack.
module pc_gen #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter int              RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            res,
    input  logic            stall,
    input  logic            fetch_ready,
    input  logic            redirect_en,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            trap_en,
    input  logic            trap_ret,
    input  logic            ras_push,
    input  logic [XLEN-1:0] ras_push_addr,
    input  logic            ras_pop,
    output logic [XLEN-1:0] pc,
    output logic            fetch_valid,
    output logic [XLEN-1:0] epc,
    output logic [XLEN-1:0] bad_addr,
    output logic            misaligned,
    output logic            ras_empty,
    output logic            ras_full
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RAS_DEPTH);

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_RUN   = 2'd1,
        S_TRAP  = 2'd2
    } state_t;

    state_t            state_r;
    logic [XLEN-1:0]   pc_r;
    logic [XLEN-1:0]   epc_r;
    logic [XLEN-1:0]   bad_addr_r;
    logic              misaligned_r;
    logic              fetch_valid_r;

    logic [XLEN-1:0]   ras_mem_r [RAS_DEPTH];
    logic [PTR_W-1:0]  ras_top_r;
    logic [CNT_W-1:0]  ras_cnt_r;
    logic              ras_empty_r;
    logic              ras_full_r;

    logic              run_s;
    logic              mis_target_s;
    logic              sel_trap_s;
    logic              sel_tret_s;
    logic              sel_mis_s;
    logic              sel_redir_s;
    logic              sel_pop_s;
    logic              sel_hold_s;
    logic              do_push_s;
    logic [XLEN-1:0]   pc_next_s;
    logic [PTR_W-1:0]  ras_top_next_s;
    logic [CNT_W-1:0]  ras_cnt_next_s;
    logic [PTR_W-1:0]  ras_wr_idx_s;

    // Decode which next-pc source wins this cycle (strict priority).
    always_comb begin
        run_s        = (state_r == S_RUN);
        mis_target_s = (redirect_pc[1:0] != 2'b00);
        sel_trap_s   = run_s && trap_en;
        sel_tret_s   = run_s && !trap_en && trap_ret;
        sel_mis_s    = run_s && !trap_en && !trap_ret && redirect_en && mis_target_s;
        sel_redir_s  = run_s && !trap_en && !trap_ret && redirect_en && !mis_target_s;
        sel_pop_s    = run_s && !trap_en && !trap_ret && !redirect_en && ras_pop
                       && (ras_cnt_r != {CNT_W{1'b0}});
        sel_hold_s   = stall || !fetch_ready;
        // A push is a call side effect; only a trap or bad target cancels it.
        do_push_s    = run_s && ras_push && !trap_en && !(redirect_en && mis_target_s);
    end

    // Next pc for the non-trapping S_RUN paths.
    always_comb begin
        pc_next_s = pc_r;
        if (sel_tret_s) begin
            pc_next_s = epc_r;
        end else if (sel_redir_s) begin
            pc_next_s = redirect_pc;
        end else if (sel_pop_s) begin
            pc_next_s = ras_mem_r[ras_top_r];
        end else if (sel_hold_s) begin
            pc_next_s = pc_r;
        end else begin
            pc_next_s = pc_r + XLEN'(4);
        end
    end

    // RAS pointer/count update; push+pop rewrites the top slot in place.
    always_comb begin
        ras_top_next_s = ras_top_r;
        ras_cnt_next_s = ras_cnt_r;
        ras_wr_idx_s   = ras_top_r + PTR_W'(1);
        if (do_push_s && sel_pop_s) begin
            ras_wr_idx_s = ras_top_r;
        end else if (do_push_s) begin
            ras_top_next_s = ras_top_r + PTR_W'(1);
            if (ras_cnt_r != DEPTH_C) begin
                ras_cnt_next_s = ras_cnt_r + CNT_W'(1);
            end else begin
                ras_cnt_next_s = ras_cnt_r;
            end
        end else if (sel_pop_s) begin
            ras_top_next_s = ras_top_r - PTR_W'(1);
            ras_cnt_next_s = ras_cnt_r - CNT_W'(1);
        end else begin
            ras_top_next_s = ras_top_r;
        end
    end

    // Control FSM with registered pc, epc, bad_addr and status outputs.
    always_ff @(posedge clk) begin
        if (!res) begin
            state_r       <= S_RESET;
            pc_r          <= RESET_VECTOR;
            epc_r         <= {XLEN{1'b0}};
            bad_addr_r    <= {XLEN{1'b0}};
            misaligned_r  <= 1'b0;
            fetch_valid_r <= 1'b0;
        end else begin
            case (state_r)
                S_RESET: begin
                    state_r       <= S_RUN;
                    fetch_valid_r <= 1'b1;
                    misaligned_r  <= 1'b0;
                end
                S_RUN: begin
                    if (sel_trap_s) begin
                        pc_r          <= TRAP_VECTOR;
                        epc_r         <= pc_r;
                        state_r       <= S_TRAP;
                        fetch_valid_r <= 1'b0;
                        misaligned_r  <= 1'b0;
                    end else if (sel_mis_s) begin
                        pc_r          <= TRAP_VECTOR;
                        epc_r         <= pc_r;
                        bad_addr_r    <= redirect_pc;
                        state_r       <= S_TRAP;
                        fetch_valid_r <= 1'b0;
                        misaligned_r  <= 1'b1;
                    end else begin
                        pc_r          <= pc_next_s;
                        state_r       <= S_RUN;
                        fetch_valid_r <= 1'b1;
                        misaligned_r  <= 1'b0;
                    end
                end
                S_TRAP: begin
                    state_r       <= S_RUN;
                    fetch_valid_r <= 1'b1;
                    misaligned_r  <= 1'b0;
                end
                default: begin
                    state_r       <= S_RESET;
                    pc_r          <= RESET_VECTOR;
                    fetch_valid_r <= 1'b0;
                    misaligned_r  <= 1'b0;
                end
            endcase
        end
    end

    // Return-address stack storage, pointer and registered flags.
    always_ff @(posedge clk) begin
        if (!res) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_mem_r[i] <= {XLEN{1'b0}};
            end
            ras_top_r   <= {PTR_W{1'b0}};
            ras_cnt_r   <= {CNT_W{1'b0}};
            ras_empty_r <= 1'b1;
            ras_full_r  <= 1'b0;
        end else begin
            if (do_push_s) begin
                ras_mem_r[ras_wr_idx_s] <= ras_push_addr;
            end
            ras_top_r   <= ras_top_next_s;
            ras_cnt_r   <= ras_cnt_next_s;
            ras_empty_r <= (ras_cnt_next_s == {CNT_W{1'b0}});
            ras_full_r  <= (ras_cnt_next_s == DEPTH_C);
        end
    end

    assign pc          = pc_r;
    assign fetch_valid = fetch_valid_r;
    assign epc         = epc_r;
    assign bad_addr    = bad_addr_r;
    assign misaligned  = misaligned_r;
    assign ras_empty   = ras_empty_r;
    assign ras_full    = ras_full_r;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: each task drives one scenario and checks
// the registered outputs one time unit after the rising edge.
module tb_pc_gen;

    logic        clk;
    logic        res;
    logic        stall;
    logic        fetch_ready;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        trap_en;
    logic        trap_ret;
    logic        ras_push;
    logic [31:0] ras_push_addr;
    logic        ras_pop;
    logic [31:0] pc;
    logic        fetch_valid;
    logic [31:0] epc;
    logic [31:0] bad_addr;
    logic        misaligned;
    logic        ras_empty;
    logic        ras_full;

    int checks;
    int errors;

    pc_gen #(
        .XLEN(32),
        .RESET_VECTOR(32'h0000_0000),
        .TRAP_VECTOR(32'h0000_0100),
        .RAS_DEPTH(4)
    ) dut (
        .clk(clk),
        .res(res),
        .stall(stall),
        .fetch_ready(fetch_ready),
        .redirect_en(redirect_en),
        .redirect_pc(redirect_pc),
        .trap_en(trap_en),
        .trap_ret(trap_ret),
        .ras_push(ras_push),
        .ras_push_addr(ras_push_addr),
        .ras_pop(ras_pop),
        .pc(pc),
        .fetch_valid(fetch_valid),
        .epc(epc),
        .bad_addr(bad_addr),
        .misaligned(misaligned),
        .ras_empty(ras_empty),
        .ras_full(ras_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall         = 1'b0;
        fetch_ready   = 1'b1;
        redirect_en   = 1'b0;
        redirect_pc   = 32'h0;
        trap_en       = 1'b0;
        trap_ret      = 1'b0;
        ras_push      = 1'b0;
        ras_push_addr = 32'h0;
        ras_pop       = 1'b0;
    endtask

    task automatic test_reset();
        res = 1'b0;
        idle_inputs();
        trap_en = 1'b1;
        tick();
        tick();
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp %h", pc, 32'h0); end
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL reset_fv got %b exp 0", fetch_valid); end
        checks++; if (epc !== 32'h0) begin errors++; $display("FAIL reset_epc got %h exp 0", epc); end
        checks++; if (ras_empty !== 1'b1 || ras_full !== 1'b0) begin errors++; $display("FAIL reset_ras got e%b f%b exp e1 f0", ras_empty, ras_full); end
        checks++; if (misaligned !== 1'b0 || bad_addr !== 32'h0) begin errors++; $display("FAIL reset_mis got %b %h exp 0 0", misaligned, bad_addr); end
        trap_en = 1'b0;
        res = 1'b1;
        tick();
        checks++; if (pc !== 32'h0 || fetch_valid !== 1'b1) begin errors++; $display("FAIL run0 got %h fv%b exp 0 fv1", pc, fetch_valid); end
        tick();
        checks++; if (pc !== 32'h4) begin errors++; $display("FAIL run4 got %h exp 4", pc); end
        tick();
        checks++; if (pc !== 32'h8 || fetch_valid !== 1'b1) begin errors++; $display("FAIL run8 got %h fv%b exp 8 fv1", pc, fetch_valid); end
    endtask

    task automatic test_stall();
        tick();
        tick();
        checks++; if (pc !== 32'h10) begin errors++; $display("FAIL pre_stall got %h exp 10", pc); end
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (pc !== 32'h10) begin errors++; $display("FAIL stall_hold got %h exp 10", pc); end
        end
        stall = 1'b0;
        fetch_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (pc !== 32'h10) begin errors++; $display("FAIL notready_hold got %h exp 10", pc); end
        end
        fetch_ready = 1'b1;
        tick();
        checks++; if (pc !== 32'h14) begin errors++; $display("FAIL after_hold got %h exp 14", pc); end
    endtask

    task automatic test_redirect_stall();
        stall = 1'b1;
        fetch_ready = 1'b0;
        redirect_en = 1'b1;
        redirect_pc = 32'h200;
        tick();
        checks++; if (pc !== 32'h200 || fetch_valid !== 1'b1) begin errors++; $display("FAIL redir_stall got %h fv%b exp 200 fv1", pc, fetch_valid); end
        idle_inputs();
        tick();
        checks++; if (pc !== 32'h204) begin errors++; $display("FAIL redir_next got %h exp 204", pc); end
    endtask

    task automatic test_misaligned();
        redirect_en = 1'b1;
        redirect_pc = 32'h40;
        tick();
        checks++; if (pc !== 32'h40) begin errors++; $display("FAIL to40 got %h exp 40", pc); end
        redirect_pc = 32'h202;
        ras_push = 1'b1;
        ras_push_addr = 32'h5550;
        tick();
        checks++; if (pc !== 32'h100) begin errors++; $display("FAIL mis_pc got %h exp 100", pc); end
        checks++; if (misaligned !== 1'b1) begin errors++; $display("FAIL mis_pulse got %b exp 1", misaligned); end
        checks++; if (bad_addr !== 32'h202) begin errors++; $display("FAIL mis_bad got %h exp 202", bad_addr); end
        checks++; if (epc !== 32'h40) begin errors++; $display("FAIL mis_epc got %h exp 40", epc); end
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL mis_fv got %b exp 0", fetch_valid); end
        checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL mis_push_dropped got %b exp 1", ras_empty); end
        idle_inputs();
        tick();
        checks++; if (pc !== 32'h100 || fetch_valid !== 1'b1 || misaligned !== 1'b0) begin errors++; $display("FAIL trap_exit got %h fv%b m%b exp 100 fv1 m0", pc, fetch_valid, misaligned); end
        trap_ret = 1'b1;
        tick();
        checks++; if (pc !== 32'h40) begin errors++; $display("FAIL trap_ret got %h exp 40", pc); end
        idle_inputs();
    endtask

    task automatic test_trap_priority();
        redirect_en = 1'b1;
        redirect_pc = 32'h80;
        tick();
        checks++; if (pc !== 32'h80) begin errors++; $display("FAIL to80 got %h exp 80", pc); end
        trap_en = 1'b1;
        trap_ret = 1'b1;
        redirect_pc = 32'h300;
        tick();
        checks++; if (pc !== 32'h100 || epc !== 32'h80) begin errors++; $display("FAIL trap_win got %h epc %h exp 100 80", pc, epc); end
        checks++; if (fetch_valid !== 1'b0 || misaligned !== 1'b0 || bad_addr !== 32'h202) begin errors++; $display("FAIL trap_side got fv%b m%b bad %h exp 0 0 202", fetch_valid, misaligned, bad_addr); end
        trap_en = 1'b0;
        tick();
        checks++; if (pc !== 32'h100 || fetch_valid !== 1'b1) begin errors++; $display("FAIL trap_bubble got %h fv%b exp 100 fv1", pc, fetch_valid); end
        idle_inputs();
    endtask

    task automatic test_ras();
        logic [31:0] pushes [5];
        logic [31:0] pops [4];
        pushes = '{32'hA0, 32'hB0, 32'hC0, 32'hD0, 32'hE0};
        pops   = '{32'hE0, 32'hD0, 32'hC0, 32'hB0};
        ras_push = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ras_push_addr = pushes[i];
            tick();
            checks++; if (ras_full !== (i >= 3) || ras_empty !== 1'b0) begin errors++; $display("FAIL push_flags%0d got f%b e%b exp f%b e0", i, ras_full, ras_empty, (i >= 3)); end
        end
        ras_push = 1'b0;
        ras_pop = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (pc !== pops[i]) begin errors++; $display("FAIL pop%0d got %h exp %h", i, pc, pops[i]); end
        end
        checks++; if (ras_empty !== 1'b1 || ras_full !== 1'b0) begin errors++; $display("FAIL pop_empty got e%b f%b exp e1 f0", ras_empty, ras_full); end
        tick();
        checks++; if (pc !== 32'hB4) begin errors++; $display("FAIL pop_empty_inc got %h exp b4", pc); end
        idle_inputs();
    endtask

    task automatic test_push_pop_same();
        ras_push = 1'b1;
        ras_push_addr = 32'h1A0;
        tick();
        checks++; if (pc !== 32'hB8 || ras_empty !== 1'b0) begin errors++; $display("FAIL pp_push got %h e%b exp b8 e0", pc, ras_empty); end
        ras_push_addr = 32'h2B0;
        ras_pop = 1'b1;
        tick();
        checks++; if (pc !== 32'h1A0 || ras_empty !== 1'b0) begin errors++; $display("FAIL pp_both got %h e%b exp 1a0 e0", pc, ras_empty); end
        ras_push = 1'b0;
        tick();
        checks++; if (pc !== 32'h2B0 || ras_empty !== 1'b1) begin errors++; $display("FAIL pp_pop got %h e%b exp 2b0 e1", pc, ras_empty); end
        idle_inputs();
    endtask

    task automatic test_wrap();
        redirect_en = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        checks++; if (pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_set got %h exp fffffffc", pc); end
        idle_inputs();
        tick();
        checks++; if (pc !== 32'h0 || fetch_valid !== 1'b1) begin errors++; $display("FAIL wrap got %h fv%b exp 0 fv1", pc, fetch_valid); end
    endtask

    task automatic test_midreset();
        ras_push = 1'b1;
        ras_push_addr = 32'h700;
        tick();
        checks++; if (ras_empty !== 1'b0) begin errors++; $display("FAIL mr_push got %b exp 0", ras_empty); end
        ras_push = 1'b0;
        trap_en = 1'b1;
        res = 1'b0;
        tick();
        checks++; if (pc !== 32'h0 || fetch_valid !== 1'b0 || epc !== 32'h0) begin errors++; $display("FAIL mr_state got %h fv%b epc %h exp 0 0 0", pc, fetch_valid, epc); end
        checks++; if (bad_addr !== 32'h0 || ras_empty !== 1'b1 || ras_full !== 1'b0) begin errors++; $display("FAIL mr_clear got %h e%b f%b exp 0 1 0", bad_addr, ras_empty, ras_full); end
        res = 1'b1;
        idle_inputs();
        tick();
        checks++; if (pc !== 32'h0 || fetch_valid !== 1'b1) begin errors++; $display("FAIL mr_run got %h fv%b exp 0 fv1", pc, fetch_valid); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_stall();
        test_redirect_stall();
        test_misaligned();
        test_trap_priority();
        test_ras();
        test_push_pop_same();
        test_wrap();
        test_midreset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
